// File: rtl/clock_pkg.sv
// Shared time-of-day constants, FSM/field encodings and wrap arithmetic
// used by the time-setting controller and digital_clock.
package clock_pkg;

    localparam int HOUR_W = 5;
    localparam int MS_W   = 6;

    localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
    localparam logic [MS_W-1:0]   MAX_MS   = 6'd59;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SET_HR  = 3'd1,
        ST_SET_MIN = 3'd2,
        ST_SET_SEC = 3'd3,
        ST_COMMIT  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FIELD_NONE = 2'b00,
        FIELD_HOUR = 2'b01,
        FIELD_MIN  = 2'b10,
        FIELD_SEC  = 2'b11
    } field_t;

    // Increment with wrap to zero past max_v (compare only, no divider).
    function automatic logic [MS_W-1:0] wrap_inc(input logic [MS_W-1:0] v,
                                                 input logic [MS_W-1:0] max_v);
        return (v >= max_v) ? '0 : v + 1'b1;
    endfunction

    // Decrement with wrap from zero to max_v.
    function automatic logic [MS_W-1:0] wrap_dec(input logic [MS_W-1:0] v,
                                                 input logic [MS_W-1:0] max_v);
        return (v == '0 || v > max_v) ? max_v : v - 1'b1;
    endfunction

    // Out-of-range live values are captured as zero.
    function automatic logic [MS_W-1:0] clamp_max(input logic [MS_W-1:0] v,
                                                  input logic [MS_W-1:0] max_v);
        return (v > max_v) ? '0 : v;
    endfunction

    function automatic logic is_set(input state_t s);
        return (s == ST_SET_HR) || (s == ST_SET_MIN) || (s == ST_SET_SEC);
    endfunction

    function automatic field_t field_of(input state_t s);
        case (s)
            ST_SET_HR:  return FIELD_HOUR;
            ST_SET_MIN: return FIELD_MIN;
            ST_SET_SEC: return FIELD_SEC;
            default:    return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Button, live-time and display/overwrite signals of the time-setting
// controller. master = controller side, slave = buttons/clock/display side.
interface time_set_ctrl_if;
    import clock_pkg::*;

    logic                         btn_mode;
    logic                         btn_inc;
    logic                         btn_dec;
    logic [HOUR_W-1:0]            cur_hour;
    logic [MS_W-1:0]              cur_min;
    logic [MS_W-1:0]              cur_sec;
    logic [HOUR_W+2*MS_W-1:0]     time_in;
    logic                         time_ow;
    logic                         edit_active;
    logic [1:0]                   edit_field;
    logic                         blink;

    modport master (
        input  btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec,
        output time_in, time_ow, edit_active, edit_field, blink
    );

    modport slave (
        output btn_mode, btn_inc, btn_dec, cur_hour, cur_min, cur_sec,
        input  time_in, time_ow, edit_active, edit_field, blink
    );

endinterface

// File: rtl/blink_gen.sv
// Square-wave generator for the edited-field blink. Output is held at 1
// while disabled or restarted so a freshly edited digit shows at once.
module blink_gen #(
    parameter int HALF_CYCLES = 12_500_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic blink
);

    localparam int CNT_W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

    logic [CNT_W-1:0] cnt;

    // Count half-periods and toggle; restart/disable force visible state.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable || restart) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (cnt == CNT_W'(HALF_CYCLES - 1)) begin
            cnt   <= '0;
            blink <= ~blink;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time-setting controller: captures live time, lets the user
// edit hour/minute/second, then drives an overwrite strobe for OW_CYCLES.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int TIMEOUT_CYCLES    = 500_000_000,
    parameter int OW_CYCLES         = 4,
    parameter int BLINK_HALF_CYCLES = 12_500_000
) (
    input  logic            clk,
    input  logic            rst_n,
    time_set_ctrl_if.master bus
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam int OW_W = $clog2(OW_CYCLES + 1);

    state_t            state_q, state_nxt;
    logic [HOUR_W-1:0] hour_q, hour_nxt;
    logic [MS_W-1:0]   min_q, min_nxt;
    logic [MS_W-1:0]   sec_q, sec_nxt;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_nxt;
    logic [OW_W-1:0]   ow_cnt_q, ow_cnt_nxt;
    logic              time_ow_q;
    logic              edit_active_q;
    field_t            field_q;
    logic              blink_restart;
    logic              blink_enable;

    logic btn_any, btn_step, timeout_hit, ow_done;

    assign btn_any     = bus.btn_mode | bus.btn_inc | bus.btn_dec;
    // Simultaneous inc+dec cancels out.
    assign btn_step    = bus.btn_inc ^ bus.btn_dec;
    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
    assign ow_done     = (ow_cnt_q == OW_W'(OW_CYCLES - 1));

    // Next-state, edit-register updates and counter/blink control.
    always_comb begin
        state_nxt     = state_q;
        hour_nxt      = hour_q;
        min_nxt       = min_q;
        sec_nxt       = sec_q;
        to_cnt_nxt    = '0;
        ow_cnt_nxt    = '0;
        blink_enable  = 1'b0;
        blink_restart = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.btn_mode) begin
                    state_nxt = ST_SET_HR;
                    hour_nxt  = HOUR_W'(clamp_max({1'b0, bus.cur_hour}, {1'b0, MAX_HOUR}));
                    min_nxt   = clamp_max(bus.cur_min, MAX_MS);
                    sec_nxt   = clamp_max(bus.cur_sec, MAX_MS);
                end
            end
            ST_SET_HR: begin
                if (bus.btn_mode) begin
                    state_nxt = ST_SET_MIN;
                end else if (btn_step) begin
                    hour_nxt = bus.btn_inc
                             ? HOUR_W'(wrap_inc({1'b0, hour_q}, {1'b0, MAX_HOUR}))
                             : HOUR_W'(wrap_dec({1'b0, hour_q}, {1'b0, MAX_HOUR}));
                end else if (!btn_any && timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SET_MIN: begin
                if (bus.btn_mode) begin
                    state_nxt = ST_SET_SEC;
                end else if (btn_step) begin
                    min_nxt = bus.btn_inc ? wrap_inc(min_q, MAX_MS) : wrap_dec(min_q, MAX_MS);
                end else if (!btn_any && timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_SET_SEC: begin
                if (bus.btn_mode) begin
                    state_nxt = ST_COMMIT;
                end else if (btn_step) begin
                    sec_nxt = bus.btn_inc ? wrap_inc(sec_q, MAX_MS) : wrap_dec(sec_q, MAX_MS);
                end else if (!btn_any && timeout_hit) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (ow_done) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Idle time only accumulates while staying in a SET state untouched.
        if (is_set(state_nxt) && (state_nxt == state_q) && !btn_any) begin
            to_cnt_nxt = to_cnt_q + 1'b1;
        end

        if ((state_q == ST_COMMIT) && (state_nxt == ST_COMMIT)) begin
            ow_cnt_nxt = ow_cnt_q + 1'b1;
        end

        blink_enable  = is_set(state_nxt);
        blink_restart = is_set(state_nxt) &&
                        ((state_nxt != state_q) || bus.btn_inc || bus.btn_dec);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Edit registers, timeout counter and overwrite-stretch counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hour_q   <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            to_cnt_q <= '0;
            ow_cnt_q <= '0;
        end else begin
            hour_q   <= hour_nxt;
            min_q    <= min_nxt;
            sec_q    <= sec_nxt;
            to_cnt_q <= to_cnt_nxt;
            ow_cnt_q <= ow_cnt_nxt;
        end
    end

    // Registered status outputs, aligned with the state they describe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            time_ow_q     <= 1'b0;
            edit_active_q <= 1'b0;
            field_q       <= FIELD_NONE;
        end else begin
            time_ow_q     <= (state_nxt == ST_COMMIT);
            edit_active_q <= (state_nxt != ST_IDLE);
            field_q       <= field_of(state_nxt);
        end
    end

    blink_gen #(
        .HALF_CYCLES (BLINK_HALF_CYCLES)
    ) u_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (blink_restart),
        .enable  (blink_enable),
        .blink   (bus.blink)
    );

    assign bus.time_in     = {hour_q, min_q, sec_q};
    assign bus.time_ow     = time_ow_q;
    assign bus.edit_active = edit_active_q;
    assign bus.edit_field  = field_q;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Testbench for time_set_ctrl: table of button vectors with expected
// outputs, plus hand-written multi-cycle sequences, checked via a queue.
module tb_time_set_ctrl;
    import clock_pkg::*;

    localparam int TO = 20;
    localparam int OW = 4;
    localparam int BH = 3;

    localparam logic [1:0] FN = 2'b00;
    localparam logic [1:0] FH = 2'b01;
    localparam logic [1:0] FM = 2'b10;
    localparam logic [1:0] FS = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    time_set_ctrl_if bus();

    time_set_ctrl #(
        .TIMEOUT_CYCLES    (TO),
        .OW_CYCLES         (OW),
        .BLINK_HALF_CYCLES (BH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          m;
        bit          i;
        bit          d;
        bit          ow;
        logic [1:0]  f;
        bit          act;
        logic [16:0] tin;
        int          bl;   // 0/1 expected blink, 2 = not checked
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [16:0] tv(input int h, input int m, input int s);
        return {h[4:0], m[5:0], s[5:0]};
    endfunction

    function automatic vec_t mkv(input bit m, input bit i, input bit d, input bit ow,
                                 input logic [1:0] f, input bit act,
                                 input logic [16:0] tin, input int bl);
        vec_t v;
        v.m = m; v.i = i; v.d = d; v.ow = ow; v.f = f; v.act = act; v.tin = tin; v.bl = bl;
        return v;
    endfunction

    task automatic check(input string name);
        vec_t e;
        bit   bad;
        e = exp_q.pop_front();
        n_vec++;
        bad = (bus.time_ow !== e.ow) || (bus.edit_field !== e.f) ||
              (bus.edit_active !== e.act) || (bus.time_in !== e.tin) ||
              ((e.bl != 2) && (bus.blink !== e.bl[0]));
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got ow=%0b fld=%b act=%0b tin=%05h blink=%0b; want ow=%0b fld=%b act=%0b tin=%05h blink=%0d",
                     name, bus.time_ow, bus.edit_field, bus.edit_active, bus.time_in, bus.blink,
                     e.ow, e.f, e.act, e.tin, e.bl);
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        exp_q.push_back(v);
        bus.btn_mode = v.m;
        bus.btn_inc  = v.i;
        bus.btn_dec  = v.d;
        @(posedge clk);
        #1;
        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        check(name);
    endtask

    task automatic commit_tail(input logic [16:0] t, input string name);
        apply(mkv(1, 0, 0, 1, FN, 1, t, 1), {name, "_ow1"});
        for (int k = 2; k <= OW; k++)
            apply(mkv(0, 0, 0, 1, FN, 1, t, 1), $sformatf("%s_ow%0d", name, k));
        apply(mkv(0, 0, 0, 0, FN, 0, t, 1), {name, "_owend"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bl_seq[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 0};

        // Full set sequence table: starts from IDLE with edit regs cleared.
        tbl.push_back(mkv(0, 0, 0, 0, FN, 0, tv(0, 0, 0), 1));
        tbl.push_back(mkv(1, 0, 0, 0, FH, 1, tv(12, 34, 56), 1));
        for (int k = 1; k <= 12; k++)
            tbl.push_back(mkv(0, 1, 0, 0, FH, 1, tv((12 + k) % 24, 34, 56), 1));
        tbl.push_back(mkv(1, 0, 0, 0, FM, 1, tv(0, 34, 56), 1));
        tbl.push_back(mkv(0, 0, 1, 0, FM, 1, tv(0, 33, 56), 1));
        tbl.push_back(mkv(1, 0, 0, 0, FS, 1, tv(0, 33, 56), 1));
        tbl.push_back(mkv(1, 0, 0, 1, FN, 1, tv(0, 33, 56), 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mkv(0, 0, 0, 1, FN, 1, tv(0, 33, 56), 1));
        for (int k = 0; k < 2; k++)
            tbl.push_back(mkv(0, 0, 0, 0, FN, 0, tv(0, 33, 56), 1));

        bus.btn_mode = 1'b0;
        bus.btn_inc  = 1'b0;
        bus.btn_dec  = 1'b0;
        bus.cur_hour = 5'd0;
        bus.cur_min  = 6'd0;
        bus.cur_sec  = 6'd0;

        // Reset state, and pulses during reset have no effect.
        rst_n = 1'b0;
        apply(mkv(0, 0, 0, 0, FN, 0, tv(0, 0, 0), 1), "reset_state");
        apply(mkv(1, 0, 0, 0, FN, 0, tv(0, 0, 0), 1), "reset_mode_blocked");
        rst_n = 1'b1;
        bus.cur_hour = 5'd12; bus.cur_min = 6'd34; bus.cur_sec = 6'd56;
        apply(mkv(1, 0, 0, 0, FH, 1, tv(12, 34, 56), 1), "rst_enter");
        apply(mkv(0, 1, 0, 0, FH, 1, tv(13, 34, 56), 1), "rst_inc");
        rst_n = 1'b0;
        apply(mkv(1, 0, 0, 0, FN, 0, tv(0, 0, 0), 1), "rst_mid1");
        apply(mkv(0, 1, 0, 0, FN, 0, tv(0, 0, 0), 1), "rst_mid2");
        rst_n = 1'b1;
        apply(mkv(0, 0, 0, 0, FN, 0, tv(0, 0, 0), 1), "rst_release");

        // Full set from 12:34:56.
        foreach (tbl[k])
            apply(tbl[k], $sformatf("full_set[%0d]", k));

        // Wraps and capture clamping (hour 30 and minute 60 capture as 0).
        bus.cur_hour = 5'd30; bus.cur_min = 6'd60; bus.cur_sec = 6'd59;
        apply(mkv(1, 0, 0, 0, FH, 1, tv(0, 0, 59), 1), "clamp_capture");
        apply(mkv(0, 0, 1, 0, FH, 1, tv(23, 0, 59), 1), "hour_dec_wrap");
        apply(mkv(1, 0, 0, 0, FM, 1, tv(23, 0, 59), 1), "to_min");
        apply(mkv(0, 0, 1, 0, FM, 1, tv(23, 59, 59), 1), "min_dec_wrap");
        apply(mkv(1, 0, 0, 0, FS, 1, tv(23, 59, 59), 1), "to_sec");
        apply(mkv(0, 1, 0, 0, FS, 1, tv(23, 59, 0), 1), "sec_inc_wrap");
        commit_tail(tv(23, 59, 0), "wrap_commit");

        // Timeout in SET_MIN after 20 idle cycles.
        bus.cur_hour = 5'd5; bus.cur_min = 6'd10; bus.cur_sec = 6'd20;
        apply(mkv(1, 0, 0, 0, FH, 1, tv(5, 10, 20), 1), "to_enter");
        apply(mkv(1, 0, 0, 0, FM, 1, tv(5, 10, 20), 1), "to_min");
        for (int k = 1; k < TO; k++)
            apply(mkv(0, 0, 0, 0, FM, 1, tv(5, 10, 20), 2), $sformatf("to_wait%0d", k));
        apply(mkv(0, 0, 0, 0, FN, 0, tv(5, 10, 20), 1), "to_expire");

        // Timeout restarted by an inc at cycle 15.
        apply(mkv(1, 0, 0, 0, FH, 1, tv(5, 10, 20), 1), "to2_enter");
        apply(mkv(1, 0, 0, 0, FM, 1, tv(5, 10, 20), 1), "to2_min");
        for (int k = 1; k < 15; k++)
            apply(mkv(0, 0, 0, 0, FM, 1, tv(5, 10, 20), 2), $sformatf("to2_wait%0d", k));
        apply(mkv(0, 1, 0, 0, FM, 1, tv(5, 11, 20), 1), "to2_inc15");
        for (int k = 16; k < 15 + TO; k++)
            apply(mkv(0, 0, 0, 0, FM, 1, tv(5, 11, 20), 2), $sformatf("to2_wait%0d", k));
        apply(mkv(0, 0, 0, 0, FN, 0, tv(5, 11, 20), 1), "to2_expire");

        // inc+dec together: field unchanged, timeout restarts.
        apply(mkv(1, 0, 0, 0, FH, 1, tv(5, 10, 20), 1), "sim_enter");
        for (int k = 1; k <= 10; k++)
            apply(mkv(0, 0, 0, 0, FH, 1, tv(5, 10, 20), 2), $sformatf("sim_wait%0d", k));
        apply(mkv(0, 1, 1, 0, FH, 1, tv(5, 10, 20), 1), "sim_incdec");
        for (int k = 1; k < TO; k++)
            apply(mkv(0, 0, 0, 0, FH, 1, tv(5, 10, 20), 2), $sformatf("sim_hold%0d", k));
        apply(mkv(0, 0, 0, 0, FN, 0, tv(5, 10, 20), 1), "sim_expire");

        // mode+inc: mode wins; buttons ignored during COMMIT.
        apply(mkv(1, 0, 0, 0, FH, 1, tv(5, 10, 20), 1), "pri_enter");
        apply(mkv(1, 1, 0, 0, FM, 1, tv(5, 10, 20), 1), "pri_mode_inc");
        apply(mkv(1, 0, 0, 0, FS, 1, tv(5, 10, 20), 1), "pri_sec");
        apply(mkv(1, 0, 0, 1, FN, 1, tv(5, 10, 20), 1), "cm_ow1");
        apply(mkv(0, 1, 0, 1, FN, 1, tv(5, 10, 20), 1), "cm_inc_ow2");
        apply(mkv(1, 0, 0, 1, FN, 1, tv(5, 10, 20), 1), "cm_mode_ow3");
        apply(mkv(0, 0, 1, 1, FN, 1, tv(5, 10, 20), 1), "cm_dec_ow4");
        apply(mkv(0, 0, 0, 0, FN, 0, tv(5, 10, 20), 1), "cm_end");
        apply(mkv(0, 0, 0, 0, FN, 0, tv(5, 10, 20), 1), "cm_idle");

        // Reset during COMMIT cycle 2 aborts the overwrite.
        apply(mkv(1, 0, 0, 0, FH, 1, tv(5, 10, 20), 1), "rc_enter");
        apply(mkv(1, 0, 0, 0, FM, 1, tv(5, 10, 20), 1), "rc_min");
        apply(mkv(1, 0, 0, 0, FS, 1, tv(5, 10, 20), 1), "rc_sec");
        apply(mkv(1, 0, 0, 1, FN, 1, tv(5, 10, 20), 1), "rc_ow1");
        apply(mkv(0, 0, 0, 1, FN, 1, tv(5, 10, 20), 1), "rc_ow2");
        rst_n = 1'b0;
        apply(mkv(0, 0, 0, 0, FN, 0, tv(0, 0, 0), 1), "rc_reset");
        rst_n = 1'b1;
        for (int k = 1; k <= 3; k++)
            apply(mkv(0, 0, 0, 0, FN, 0, tv(0, 0, 0), 1), $sformatf("rc_after%0d", k));

        // Blink in SET_SEC: 3 cycles on, 3 off; snaps to 1 on inc.
        apply(mkv(1, 0, 0, 0, FH, 1, tv(5, 10, 20), 1), "bl_enter");
        apply(mkv(1, 0, 0, 0, FM, 1, tv(5, 10, 20), 1), "bl_min");
        apply(mkv(1, 0, 0, 0, FS, 1, tv(5, 10, 20), 1), "bl_sec");
        for (int k = 0; k < 9; k++)
            apply(mkv(0, 0, 0, 0, FS, 1, tv(5, 10, 20), bl_seq[k]), $sformatf("bl_cyc%0d", k + 1));
        apply(mkv(0, 1, 0, 0, FS, 1, tv(5, 10, 21), 1), "bl_inc");
        apply(mkv(0, 0, 0, 0, FS, 1, tv(5, 10, 21), 1), "bl_post1");
        apply(mkv(0, 0, 0, 0, FS, 1, tv(5, 10, 21), 1), "bl_post2");
        apply(mkv(0, 0, 0, 0, FS, 1, tv(5, 10, 21), 0), "bl_post3");
        commit_tail(tv(5, 10, 21), "bl_commit");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
